// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipelined ARM core.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant: a lone requester wins; on contention D wins unless D won last.
import arm_pipe_pkg::*;

module arb_rr2 (
  input  logic i_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic gnt
);

  always_comb begin
    gnt = GNT_I;
    if (d_req && !(i_req && last_gnt == GNT_D)) gnt = GNT_D;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch (I) and memory (D) stages.
import arm_pipe_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallF,
  output logic              StallM
);

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  arb_state_t        state;
  logic              gnt;
  logic              lastGnt;
  logic              nextGnt;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdataQ;

  arb_rr2 uArb (
    .i_req   (i_req),
    .d_req   (d_req),
    .last_gnt(lastGnt),
    .gnt     (nextGnt)
  );

  always_ff @(posedge clk)
    assert (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 15)
      else $error("mem_port_arbiter: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);

  // mem_addr/mem_wdata/mem_we double as the request latches held through ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      gnt       <= GNT_I;
      lastGnt   <= GNT_I;
      cnt       <= '0;
      rdataQ    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            gnt       <= nextGnt;
            lastGnt   <= nextGnt;
            cnt       <= '0;
            mem_en    <= 1'b1;
            mem_we    <= (nextGnt == GNT_D) && d_we;
            mem_addr  <= (nextGnt == GNT_D) ? d_addr : i_addr;
            mem_wdata <= (nextGnt == GNT_D) ? d_wdata : '0;
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LastCnt) begin
            rdataQ  <= mem_rdata;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            i_ready <= (gnt == GNT_I);
            d_ready <= (gnt == GNT_D);
            state   <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign i_rdata = i_ready ? rdataQ : '0;
  assign d_rdata = d_ready ? rdataQ : '0;
  assign StallF  = i_req & ~i_ready;
  assign StallM  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with WAIT_CYCLES=2 and a small word-addressed memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_ready, d_ready, mem_en, mem_we, StallF, StallM;

  logic [31:0] memArr [64];
  bit          memLoaded;
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .StallF(StallF), .StallM(StallM)
  );

  always #5 clk = ~clk;

  // Word k preloads to A500_00kk except word 2 (address 0x8), which holds an ADD instruction.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int k = 0; k < 64; k++) memArr[k] <= 32'hA500_0000 + 32'(k);
      memArr[2] <= 32'hE280_0001;
      memLoaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      memArr[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = memArr[mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic expD;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick; tick;
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_i_ready", {31'b0, i_ready}, 32'd0);
    check("rst_d_ready", {31'b0, d_ready}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_stallF", {31'b0, StallF}, 32'd0);
    reset = 1'b1;
    tick;

    // Single fetch of address 0x8
    i_req = 1'b1; i_addr = 32'h8;
    #1 check("f_stallF_pre", {31'b0, StallF}, 32'd1);
    tick;
    check("f_mem_en1", {31'b0, mem_en}, 32'd1);
    check("f_mem_addr", mem_addr, 32'h8);
    check("f_mem_we", {31'b0, mem_we}, 32'd0);
    check("f_stallF1", {31'b0, StallF}, 32'd1);
    tick;
    check("f_mem_en2", {31'b0, mem_en}, 32'd1);
    check("f_i_ready_early", {31'b0, i_ready}, 32'd0);
    tick;
    check("f_i_ready", {31'b0, i_ready}, 32'd1);
    check("f_i_rdata", i_rdata, 32'hE280_0001);
    check("f_mem_en_resp", {31'b0, mem_en}, 32'd0);
    check("f_stallF_done", {31'b0, StallF}, 32'd0);
    i_req = 1'b0;
    tick;
    check("f_i_ready_off", {31'b0, i_ready}, 32'd0);

    // Both held: last grant was I, so order is D, I, D, I
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    for (int r = 0; r < 4; r++) begin
      expD = (r % 2 == 0);
      tick;
      check("rr_addr", mem_addr, expD ? 32'hC : 32'h8);
      tick; tick;
      check("rr_d_ready", {31'b0, d_ready}, {31'b0, expD});
      check("rr_i_ready", {31'b0, i_ready}, {31'b0, !expD});
      check("rr_rdata", expD ? d_rdata : i_rdata, expD ? 32'hA500_0003 : 32'hE280_0001);
      if (r == 3) begin i_req = 1'b0; d_req = 1'b0; end
      tick;
    end

    // Store 0xDEADBEEF to 0x40; input address change mid-access must be ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick;
    check("st_mem_we1", {31'b0, mem_we}, 32'd1);
    check("st_mem_addr1", mem_addr, 32'h40);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_addr = 32'h80; d_wdata = 32'h0;
    tick;
    check("st_mem_we2", {31'b0, mem_we}, 32'd1);
    check("st_mem_addr2", mem_addr, 32'h40);
    check("st_mem_wdata2", mem_wdata, 32'hDEAD_BEEF);
    tick;
    check("st_d_ready", {31'b0, d_ready}, 32'd1);
    check("st_i_ready", {31'b0, i_ready}, 32'd0);
    check("st_mem_we_resp", {31'b0, mem_we}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick;
    check("st_d_ready_off", {31'b0, d_ready}, 32'd0);

    // Flush: fetch dropped in the first ACCESS cycle still completes once
    i_req = 1'b1; i_addr = 32'h10;
    tick;
    i_req = 1'b0;
    check("fl_mem_en", {31'b0, mem_en}, 32'd1);
    tick; tick;
    check("fl_i_ready", {31'b0, i_ready}, 32'd1);
    check("fl_i_rdata", i_rdata, 32'hA500_0004);
    tick;
    check("fl_i_ready_off", {31'b0, i_ready}, 32'd0);
    tick;
    check("fl_no_restart", {31'b0, mem_en}, 32'd0);

    // Back-to-back loads with d_req held
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick; tick; tick;
    check("bb_d_ready1", {31'b0, d_ready}, 32'd1);
    check("bb_d_rdata1", d_rdata, 32'hDEAD_BEEF);
    d_addr = 32'h14;
    tick;
    check("bb_gap", {31'b0, d_ready}, 32'd0);
    check("bb_stallM", {31'b0, StallM}, 32'd1);
    tick;
    check("bb_addr2", mem_addr, 32'h14);
    tick; tick;
    check("bb_d_ready2", {31'b0, d_ready}, 32'd1);
    check("bb_d_rdata2", d_rdata, 32'hA500_0005);
    d_req = 1'b0;
    tick;

    // Reset asserted in the second ACCESS cycle of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h18; d_wdata = 32'hCAFE_F00D;
    tick; tick;
    check("rw_mem_we_pre", {31'b0, mem_we}, 32'd1);
    #2 reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("rw_mem_en_async", {31'b0, mem_en}, 32'd0);
    check("rw_mem_we_async", {31'b0, mem_we}, 32'd0);
    #2 reset = 1'b1;
    tick;
    check("rw_i_ready", {31'b0, i_ready}, 32'd0);
    check("rw_d_ready", {31'b0, d_ready}, 32'd0);
    check("rw_idle_en", {31'b0, mem_en}, 32'd0);
    i_req = 1'b1; i_addr = 32'h8;
    tick;
    check("rw_restart_en", {31'b0, mem_en}, 32'd1);
    check("rw_restart_addr", mem_addr, 32'h8);
    i_req = 1'b0;
    tick; tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the fetch stage and the memory stage of the pipelined ARM core. It accepts request/ready handshakes from both stages and sequences a fixed-latency memory access for one requester at a time. It produces per-stage stall signals that the hazard logic uses to freeze the fetch and memory stages. It sits between the datapath's PCF/ALUResultM/WriteDataM nets and the memory macro, alongside the pipeline controller.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
WAIT_CYCLES, 2, memory access latency in cycles; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
i_req  in  1  fetch stage requests a read; held high until i_ready
i_addr  in  ADDR_W  fetch address (PCF)
i_rdata  out  DATA_W  fetched instruction; valid while i_ready=1
i_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  memory stage requests an access; held high until d_ready
d_we  in  1  1=write, 0=read (MemWriteM)
d_addr  in  ADDR_W  data address (ALUResultM)
d_wdata  in  DATA_W  store data (WriteDataM)
d_rdata  out  DATA_W  load data; valid while d_ready=1
d_ready  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle
StallF  out  1  i_req & ~i_ready (combinational)
StallM  out  1  d_req & ~d_ready (combinational)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Registers: state, gnt (0=I, 1=D), last_gnt, cnt[3:0], addr/wdata/we latches, rdata_q.
- Reset (reset=0, async): state=IDLE, cnt=0, gnt=0, last_gnt=0, rdata_q=0. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata. Stall outputs follow their equations.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant D, unless last_gnt=D, in which case grant I. This alternates and prevents fetch starvation.
  - On a grant: latch the address, wdata and we (we forced to 0 for I), set gnt and last_gnt, set cnt=0, go to ACCESS.
  - No request pending: stay in IDLE.
- ACCESS:
  - mem_en=1, mem_addr/mem_wdata driven from the latches, mem_we=latched we.
  - Outputs are held stable for all WAIT_CYCLES cycles.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: capture mem_rdata into rdata_q (writes capture but the value is ignored), go to RESP.
- RESP:
  - mem_en=0, mem_we=0.
  - Assert the granted port's ready for exactly one cycle and drive its rdata from rdata_q. The other port's ready stays 0 and its rdata is 0.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at edge t gets ready high in cycle t+WAIT_CYCLES+1. Minimum spacing between two accesses is WAIT_CYCLES+2 cycles.
- A request arriving during ACCESS/RESP waits. It is arbitrated on the next IDLE cycle.
- A request deasserted mid-access (e.g. pipeline flush): the access still completes (a write is committed) and ready still pulses. The requester ignores it.
- A requester that keeps req high after its ready pulse is treated as a new request in the following IDLE cycle.
- Address/data changes on the inputs during ACCESS have no effect, because the latches are used.
- Reset asserted mid-ACCESS: mem_en/mem_we drop immediately. A write in flight is not guaranteed to complete. The FSM restarts in IDLE.
- cnt width is fixed at 4 bits. WAIT_CYCLES=0 or >15 is illegal, and a simulation assertion flags it.

Decomposition:
- Shared package arm_pipe_pkg:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t
  - constants GNT_I=1'b0 and GNT_D=1'b1
- One natural sub-module: arb_rr2, the 2-requester round-robin grant logic (inputs i_req, d_req, last_gnt; output gnt). It is combinational and reusable for other shared resources.
- The FSM, counter and latches stay in the top module.

Test Plan:
All tests use WAIT_CYCLES=2.
- Single fetch: i_req=1, i_addr=0x00000008, mem returns 0xE2800001 → mem_en high for 2 cycles with mem_addr=0x8, mem_we=0; i_ready=1 with i_rdata=0xE2800001 exactly 3 cycles after the request edge; StallF high until then.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_we=1 for 2 cycles with mem_addr=0x40, mem_wdata=0xDEADBEEF; d_ready pulses for 1 cycle; i_ready stays 0.
- Simultaneous requests, both held continuously → grant order D, I, D, I; ready pulses alternate every 4 cycles; neither port stalls more than 8 cycles.
- Flush: i_req dropped in the first ACCESS cycle → access still completes, i_ready pulses once, FSM returns to IDLE, no new access starts.
- Reset mid-write: reset=0 in the second ACCESS cycle → mem_en=0 and mem_we=0 in the same cycle (async); after release, state is IDLE and all readies are 0.
- Back-to-back loads with d_req held → d_ready on cycles 3 and 7; d_rdata matches the memory contents of each address.
